// File: rtl/rv32_pkg.sv
// Shared types for the pito memory read-back engine.
//   rv32_mem_rd_beat_t : one streamed beat {addr, data, last}
//   rv32_mrd_state_e   : read-back FSM states
//   RV32_MRD_FIFO_DEPTH: default output buffer depth
package rv32_pkg;

    localparam int unsigned RV32_ADDR_W         = 10;
    localparam int unsigned RV32_DATA_W         = 32;
    localparam int unsigned RV32_MRD_FIFO_DEPTH = 4;

    typedef logic [RV32_DATA_W-1:0] rv32_data_t;

    typedef struct packed {
        logic [RV32_ADDR_W-1:0] addr;
        rv32_data_t             data;
        logic                   last;
    } rv32_mem_rd_beat_t;

    typedef enum logic [1:0] {
        MRD_IDLE  = 2'd0,
        MRD_ISSUE = 2'd1,
        MRD_DRAIN = 2'd2,
        MRD_FIN   = 2'd3
    } rv32_mrd_state_e;

endpackage

// File: rtl/rv32_mrd_fifo.sv
// Synchronous FIFO used as the read-back output buffer.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data : write request and data (ignored when full)
//   pop, pop_data   : read request and head-of-queue data (ignored when empty)
//   full, empty     : occupancy flags
//   count           : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module rv32_mrd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            // The producer's credit scheme must never push into a full buffer.
            assert (!(push && full));
        end
    end

endmodule

// File: rtl/rv32_mem_reader.sv
// Read-back engine for the pito instruction/data RAMs.
// Walks the inclusive range [addr_from, addr_to], reads a synchronous RAM with
// RD_LATENCY cycles of latency and streams {addr, data, last} over valid/ready.
// Ports:
//   rv32_io_clk, rv32_io_rst : clock, synchronous active-high reset
//   start, addr_from, addr_to: command (sampled only in IDLE)
//   busy, done, err          : status (done/err are one-cycle pulses)
//   mem_rd_en, mem_rd_addr   : RAM read request
//   mem_rd_data              : RAM read data, RD_LATENCY cycles after request
//   out_valid/out_ready      : stream handshake
//   out_addr/out_data/out_last: stream payload (last marks addr_to)
module rv32_mem_reader
    import rv32_pkg::*;
#(
    parameter int unsigned ADDR_W     = RV32_ADDR_W,
    parameter int unsigned DATA_W     = RV32_DATA_W,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH = RV32_MRD_FIFO_DEPTH
) (
    input  logic              rv32_io_clk,
    input  logic              rv32_io_rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_from,
    input  logic [ADDR_W-1:0] addr_to,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int unsigned BEAT_W = ADDR_W + DATA_W + 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    rv32_mrd_state_e   state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic              err_q, err_d;

    // Latency pipe: tracks each outstanding read so it lines up with mem_rd_data.
    logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [RD_LATENCY-1:0] pipe_last_q, pipe_last_d;
    logic [ADDR_W-1:0]     pipe_addr_q [RD_LATENCY];
    logic [ADDR_W-1:0]     pipe_addr_d [RD_LATENCY];

    logic              issue;
    logic [31:0]       inflight;
    logic              credit_ok;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [BEAT_W-1:0] fifo_in, fifo_head;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + 32'(pipe_vld_q[i]);
        end
        // Every issued read owns a FIFO slot until popped, so the buffer can never overflow.
        credit_ok = (32'(fifo_count) + inflight) < 32'(FIFO_DEPTH);
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        end_d   = end_q;
        err_d   = 1'b0;
        issue   = 1'b0;
        case (state_q)
            MRD_IDLE: begin
                if (start) begin
                    if (addr_from <= addr_to) begin
                        cur_d   = addr_from;
                        end_d   = addr_to;
                        state_d = MRD_ISSUE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            MRD_ISSUE: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    // Equality terminates the walk, so addr_to at the top of memory never wraps.
                    if (cur_q == end_q) begin
                        state_d = MRD_DRAIN;
                    end else begin
                        cur_d = cur_q + 1'b1;
                    end
                end
            end
            MRD_DRAIN: begin
                // The last word is the final push; pipe and FIFO empty means it has been popped.
                if (inflight == 32'd0 && fifo_empty) begin
                    state_d = MRD_FIN;
                end
            end
            MRD_FIN: begin
                state_d = MRD_IDLE;
            end
            default: begin
                state_d = MRD_IDLE;
            end
        endcase
    end

    always_comb begin
        pipe_vld_d     = '0;
        pipe_last_d    = '0;
        pipe_vld_d[0]  = issue;
        pipe_last_d[0] = (cur_q == end_q);
        pipe_addr_d[0] = cur_q;
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_last_d[i] = pipe_last_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
        end
    end

    always_ff @(posedge rv32_io_clk) begin
        if (rv32_io_rst) begin
            state_q     <= MRD_IDLE;
            cur_q       <= '0;
            end_q       <= '0;
            err_q       <= 1'b0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                pipe_addr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            end_q       <= end_d;
            err_q       <= err_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_last_q <= pipe_last_d;
            pipe_addr_q <= pipe_addr_d;
        end
    end

    assign fifo_push = pipe_vld_q[RD_LATENCY-1];
    assign fifo_in   = {pipe_addr_q[RD_LATENCY-1], mem_rd_data, pipe_last_q[RD_LATENCY-1]};
    assign fifo_pop  = out_valid && out_ready;

    rv32_mrd_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (rv32_io_clk),
        .rst       (rv32_io_rst),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign busy        = (state_q == MRD_ISSUE) || (state_q == MRD_DRAIN);
    assign done        = (state_q == MRD_FIN);
    assign err         = err_q;
    assign mem_rd_en   = issue;
    assign mem_rd_addr = issue ? cur_q : '0;
    // Payload is forced to zero while empty so stale storage never shows on the port.
    assign out_valid   = !fifo_empty;
    assign out_addr    = fifo_empty ? '0 : fifo_head[BEAT_W-1 -: ADDR_W];
    assign out_data    = fifo_empty ? '0 : fifo_head[DATA_W:1];
    assign out_last    = !fifo_empty && fifo_head[0];

endmodule

// File: tb/tb_rv32_mem_reader.sv
// Directed and random checks for rv32_mem_reader against a 2-cycle RAM model.
module tb_rv32_mem_reader;
    import rv32_pkg::*;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] addr_from, addr_to;
    logic          busy, done, err, mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          out_valid, out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_last;

    always #5 clk = ~clk;

    rv32_mem_reader #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .RD_LATENCY (2),
        .FIFO_DEPTH (4)
    ) dut (
        .rv32_io_clk (clk),
        .rv32_io_rst (rst),
        .start       (start),
        .addr_from   (addr_from),
        .addr_to     (addr_to),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    // RAM with registered address and registered output: two cycles of latency.
    logic [DW-1:0] ram [1024];
    logic [DW-1:0] rd_s1, rd_s2;
    always @(posedge clk) begin
        rd_s1 <= ram[mem_rd_addr];
        rd_s2 <= rd_s1;
    end
    assign mem_rd_data = rd_s2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Observation state, written only by the stimulus process.
    rv32_mem_rd_beat_t got_q[$];
    int got_cyc[$];
    int done_cnt, err_cnt, rd_cnt, rd_oob, busy_cnt, busy_at_done;
    int first_vld, stall_bad, credit_bad, outstanding;
    int lo, hi;
    logic          stall_prev;
    logic [AW-1:0] pv_addr;
    logic [DW-1:0] pv_data;
    logic          pv_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        got_q.delete();
        got_cyc.delete();
        done_cnt = 0; err_cnt = 0; rd_cnt = 0; rd_oob = 0; busy_cnt = 0;
        busy_at_done = 0; first_vld = -1; stall_bad = 0; credit_bad = 0;
    endtask

    // Observe the current cycle with the given ready, then advance past the next edge.
    task automatic step(input logic rdy);
        rv32_mem_rd_beat_t b;
        out_ready = rdy;
        if (rst) begin
            outstanding = 0;
            stall_prev  = 1'b0;
        end else begin
            if (stall_prev && (!out_valid || out_addr != pv_addr || out_data != pv_data
                               || out_last != pv_last))
                stall_bad++;
            stall_prev = out_valid && !rdy;
            pv_addr = out_addr; pv_data = out_data; pv_last = out_last;
            if (mem_rd_en) begin
                if (outstanding >= 4) credit_bad++;
                rd_cnt++;
                if (int'(mem_rd_addr) < lo || int'(mem_rd_addr) > hi) rd_oob++;
            end
            if (out_valid && first_vld < 0) first_vld = cyc;
            if (out_valid && rdy) begin
                b.addr = out_addr; b.data = out_data; b.last = out_last;
                got_q.push_back(b);
                got_cyc.push_back(cyc);
            end
            outstanding = outstanding + int'(mem_rd_en) - int'(out_valid && rdy);
            if (done) begin
                done_cnt++;
                if (busy) busy_at_done++;
            end
            if (err)  err_cnt++;
            if (busy) busy_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic pick(input int mode, input int n);
        if (mode == 0) return 1'b1;
        if (mode == 1) begin
            if (n >= 6 && n < 26) return 1'b0;
            return (n % 4 == 0) || (n % 4 == 3);
        end
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic outputs_zero(input string pfx);
        check({pfx, "_busy"},  busy, 0);
        check({pfx, "_done"},  done, 0);
        check({pfx, "_err"},   err, 0);
        check({pfx, "_rden"},  mem_rd_en, 0);
        check({pfx, "_rdadr"}, mem_rd_addr, 0);
        check({pfx, "_vld"},   out_valid, 0);
        check({pfx, "_oadr"},  out_addr, 0);
        check({pfx, "_odat"},  out_data, 0);
        check({pfx, "_olast"}, out_last, 0);
    endtask

    // mode: 0 ready held high, 1 ready 1-0-0-1 with a 20-cycle stall, 2 random ready.
    task automatic run_range(input int from, input int to, input int mode, input bit midstart);
        int len;
        int acc;
        int budget;
        int n;
        len = to - from + 1;
        budget = 40 + 6 * len;
        clear_stats();
        lo = from; hi = to;
        addr_from = AW'(from);
        addr_to   = AW'(to);
        start = 1'b1;
        step(pick(mode, 0));
        start = 1'b0;
        acc = cyc;
        check("busy_up", busy, 1);
        n = 1;
        while (n < budget && done_cnt == 0) begin
            if (midstart && n == 3) begin
                start = 1'b1; addr_from = '0; addr_to = '1;
            end else begin
                start = 1'b0;
            end
            step(pick(mode, n));
            n++;
        end
        start = 1'b0;
        step(1'b1);
        step(1'b1);
        check("beat_count", got_q.size(), len);
        for (int i = 0; i < len && i < got_q.size(); i++) begin
            check("beat_addr", got_q[i].addr, from + i);
            check("beat_data", got_q[i].data, ram[from + i]);
            check("beat_last", got_q[i].last, (i == len - 1));
        end
        check("done_once",    done_cnt, 1);
        check("rd_count",     rd_cnt, len);
        check("rd_in_range",  rd_oob, 0);
        check("stall_stable", stall_bad, 0);
        check("credit",       credit_bad, 0);
        check("busy_at_done", busy_at_done, 0);
        check("no_err",       err_cnt, 0);
        check("first_vld",    first_vld - acc, 3);
        check("busy_end",     busy, 0);
        if (mode == 0 && got_cyc.size() == len)
            check("throughput", got_cyc[len-1] - got_cyc[0], len - 1);
    endtask

    task automatic err_case(input int from, input int to);
        clear_stats();
        lo = 0; hi = 1023;
        addr_from = AW'(from);
        addr_to   = AW'(to);
        start = 1'b1;
        step(1'b1);
        start = 1'b0;
        check("err_pulse", err, 1);
        step(1'b1);
        check("err_fall", err, 0);
        step(1'b1);
        step(1'b1);
        check("err_once",   err_cnt, 1);
        check("err_nobusy", busy_cnt, 0);
        check("err_nord",   rd_cnt, 0);
        check("err_nodone", done_cnt, 0);
    endtask

    initial begin
        int to;
        int from;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; addr_from = '0; addr_to = '0;
        outstanding = 0; stall_prev = 1'b0; pv_addr = '0; pv_data = '0; pv_last = 1'b0;
        lo = 0; hi = 0;
        for (int i = 0; i < 1024; i++) ram[i] = 32'hA500_0000 + 32'(i);
        ram[1023] = 32'hDEAD_BEEF;
        clear_stats();
        @(posedge clk); #1;
        step(1'b0); step(1'b0);
        rst = 1'b0;
        outputs_zero("reset");

        run_range(0, 7, 0, 1'b0);
        run_range(16, 31, 1, 1'b0);
        run_range(1023, 1023, 0, 1'b0);
        err_case(5, 4);
        run_range(40, 49, 0, 1'b1);

        // Reset in the middle of a long run.
        clear_stats();
        lo = 0; hi = 63;
        addr_from = '0; addr_to = AW'(63);
        start = 1'b1;
        step(1'b1);
        start = 1'b0;
        for (int n = 0; n < 200 && got_q.size() < 10; n++) step(1'b1);
        check("pre_rst_beats", got_q.size(), 10);
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        outputs_zero("midrst");
        for (int n = 0; n < 8; n++) step(1'b1);
        check("midrst_nodone", done_cnt, 0);
        check("midrst_nobeat", got_q.size(), 10);
        run_range(0, 3, 0, 1'b0);

        for (int r = 0; r < 200; r++) begin
            if (r % 20 == 19) begin
                to   = int'($urandom_range(0, 1022));
                from = int'($urandom_range(to + 1, 1023));
                err_case(from, to);
            end else begin
                from = int'($urandom_range(0, 1023));
                to   = from + int'($urandom_range(0, 15));
                if (to > 1023) to = 1023;
                run_range(from, to, 2, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
